mem_access_ctrl: RTL

- Initiator side of the main-memory port: accepts one load/store request at a time from the datapath/control unit and latches it into internal MAR/MDR registers.
- Drives the RAM's read/write strobes, address and write data, then captures the RAM's registered output.
- Returns read data, or echoes store data, through a valid/ready response handshake.
- Sits between the control unit and the 512-word RAM, replacing ad-hoc MARin/MDRin/Read/Write sequencing.

---
 rtl/mem_pkg.sv | 14 +
 rtl/mem_wait_counter.sv | 36 +++
 rtl/mem_access_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the main-memory initiator: state encoding and default geometry.
package mem_pkg;

  localparam int unsigned MEM_DEPTH = 512;
  localparam int unsigned DATA_W    = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } state_e;

endpackage

// File: rtl/mem_wait_counter.sv
// Strobe-window counter: load clears it, inc advances it until WAIT_CYCLES is reached.
// done_o is registered and rises on the edge where the count reaches WAIT_CYCLES.
module mem_wait_counter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic clk_i,
  input  logic clear_ni,
  input  logic load_i,
  input  logic inc_i,
  output logic done_o
);

  localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_CYCLES);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             done_q;

  assign count_d = count_q + CNT_W'(1);
  assign done_o  = done_q;

  always_ff @(posedge clk_i) begin
    if (!clear_ni) begin
      count_q <= '0;
      done_q  <= 1'b0;
    end else if (load_i) begin
      count_q <= '0;
      done_q  <= (WAIT_CYCLES == 0);
    end else if (inc_i && !done_q) begin
      count_q <= count_d;
      done_q  <= (count_d == LAST);
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Main-memory initiator: latches one load/store into MAR/MDR, sequences the RAM strobes
// for WAIT_CYCLES+1 cycles, then returns data (or an out-of-range error) via valid/ready.
module mem_access_ctrl #(
  parameter int unsigned DEPTH       = mem_pkg::MEM_DEPTH,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned DATA_W      = mem_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  import mem_pkg::*;

  localparam logic [DATA_W-1:0] DEPTH_L = DATA_W'(DEPTH);

  state_e            state_q;
  logic [DATA_W-1:0] mar_q;
  logic [DATA_W-1:0] mdr_q;
  logic              we_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic              busy_q;

  logic              accept_ok_c;
  logic              cnt_inc_c;
  logic              cnt_done;

  // Full-width compare: no wrap, DEPTH itself is already out of range.
  assign accept_ok_c = (state_q == IDLE) && req_valid && (req_addr < DEPTH_L);
  assign cnt_inc_c   = (state_q == ACCESS);

  mem_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk_i   (clock),
    .clear_ni(clear),
    .load_i  (accept_ok_c),
    .inc_i   (cnt_inc_c),
    .done_o  (cnt_done)
  );

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q      <= IDLE;
      mar_q        <= '0;
      mdr_q        <= '0;
      we_q         <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            mar_q       <= req_addr;
            mdr_q       <= req_wdata;
            we_q        <= req_we;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (req_addr >= DEPTH_L) begin
              state_q      <= ERR;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state_q     <= ACCESS;
              mem_read_q  <= !req_we;
              mem_write_q <= req_we;
            end
          end
        end
        ACCESS: begin
          // Strobe window closes here; a load captures the RAM output into MDR.
          if (cnt_done) begin
            state_q      <= RESP;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            if (!we_q) begin
              mdr_q        <= mem_rdata;
              resp_rdata_q <= mem_rdata;
            end else begin
              resp_rdata_q <= mdr_q;
            end
          end
        end
        RESP, ERR: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
          end
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mar_q;
  assign mem_wdata  = mdr_q;
  assign busy       = busy_q;

endmodule
